// File: rtl/memory_bist_pkg.sv
// Shared types and constants for the memory BIST controller.
// LFSR polynomial and step function live here so both users agree on them.
package memory_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FILL,
        ST_RD_WORD,
        ST_RD_BYTE,
        ST_RD_BIT,
        ST_DONE
    } state_e;

    localparam logic [1:0] OP_WORD = 2'd0;
    localparam logic [1:0] OP_BIT  = 2'd1;
    localparam logic [1:0] OP_BYTE = 2'd2;

    localparam logic [1:0] PH_WORD = 2'd0;
    localparam logic [1:0] PH_BYTE = 2'd1;
    localparam logic [1:0] PH_BIT  = 2'd2;

    localparam logic [31:0] LFSR_POLY    = 32'h80200003;
    localparam logic [31:0] DEFAULT_SEED = 32'h1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois LFSR pattern generator with load and step controls.
// Load has priority over step.
module bist_lfsr32
    import memory_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/memory_bist_ctrl.sv
// BIST initiator: clear, LFSR fill, then word/byte/bit readback checks.
// Owns the memory port while busy; system side sees start/done only.
module memory_bist_ctrl
    import memory_bist_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [9:0]  err_count,
    output logic [7:0]  first_fail_addr,
    output logic [1:0]  first_fail_phase,
    output logic        WrEn,
    output logic        RdEn,
    output logic [1:0]  RdEn_Opcode,
    output logic [7:0]  Addr,
    output logic [4:0]  BitAddr,
    output logic [1:0]  ByteAddr,
    output logic [31:0] WrBus,
    input  logic [31:0] RdBus
);

    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);
    localparam logic [1:0] LAST_LAT  = 2'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] seed_q, seed_d;
    logic [9:0]  err_q, err_d;
    logic [7:0]  ffa_q, ffa_d;
    logic [1:0]  ffp_q, ffp_d;
    logic        pass_q, pass_d;

    logic [31:0] exp_w, seed_fix, lfsr_seed;
    logic [1:0]  phase;
    logic        idle, accept, kill, is_wr, is_rd;
    logic        rd_last, adv, wrap, mism, lfsr_load, lfsr_step;

    assign seed_fix = (seed == 32'h0) ? DEFAULT_SEED : seed;
    assign idle     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept   = idle && start && !abort;
    assign kill     = !idle && abort;
    assign is_wr    = state_q inside {ST_CLEAR, ST_FILL};
    assign is_rd    = state_q inside {ST_RD_WORD, ST_RD_BYTE, ST_RD_BIT};
    assign rd_last  = is_rd && (lat_q == LAST_LAT);
    assign adv      = !abort && (is_wr || rd_last);
    assign wrap     = adv && (addr_q == LAST_ADDR);

    // Every phase after FILL replays the same sequence from the seed
    assign lfsr_load = accept ||
        (wrap && (state_q inside {ST_FILL, ST_RD_WORD, ST_RD_BYTE}));
    assign lfsr_seed = accept ? seed_fix : seed_q;
    assign lfsr_step = adv && (state_q != ST_CLEAR);

    bist_lfsr32 u_lfsr (
        .clk     (clk),
        .rst_ni  (reset),
        .load_i  (lfsr_load),
        .seed_i  (lfsr_seed),
        .step_i  (lfsr_step),
        .state_o (exp_w)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_CLEAR;
        end else if (kill) begin
            state_d = ST_IDLE;
        end else if (wrap) begin
            unique case (state_q)
                ST_CLEAR:   state_d = ST_FILL;
                ST_FILL:    state_d = ST_RD_WORD;
                ST_RD_WORD: state_d = ST_RD_BYTE;
                ST_RD_BYTE: state_d = ST_RD_BIT;
                ST_RD_BIT:  state_d = ST_DONE;
                default:    state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy        = !idle;
        done        = (state_q == ST_DONE);
        WrEn        = is_wr;
        RdEn        = is_rd;
        Addr        = addr_q;
        WrBus       = (state_q == ST_FILL) ? exp_w : 32'h0;
        RdEn_Opcode = OP_WORD;
        BitAddr     = 5'd0;
        ByteAddr    = 2'd0;
        unique case (state_q)
            ST_RD_BYTE: begin
                RdEn_Opcode = OP_BYTE;
                ByteAddr    = addr_q[1:0];
            end
            ST_RD_BIT: begin
                RdEn_Opcode = OP_BIT;
                BitAddr     = addr_q[4:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        mism  = 1'b0;
        phase = PH_WORD;
        unique case (state_q)
            ST_RD_WORD: mism = (RdBus != exp_w);
            ST_RD_BYTE: begin
                phase = PH_BYTE;
                mism  = (RdBus[7:0] != exp_w[{addr_q[1:0], 3'b000} +: 8]);
            end
            ST_RD_BIT: begin
                phase = PH_BIT;
                mism  = (RdBus[0] != exp_w[addr_q[4:0]]);
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        lat_d  = lat_q;
        seed_d = seed_q;
        err_d  = err_q;
        ffa_d  = ffa_q;
        ffp_d  = ffp_q;
        pass_d = pass_q;
        if (accept) begin
            addr_d = 8'd0;
            lat_d  = 2'd0;
            seed_d = seed_fix;
            err_d  = 10'd0;
            ffa_d  = 8'd0;
            ffp_d  = 2'd0;
            pass_d = 1'b0;
        end else if (kill) begin
            addr_d = 8'd0;
            lat_d  = 2'd0;
        end else begin
            if (is_rd) begin
                lat_d = rd_last ? 2'd0 : lat_q + 2'd1;
            end
            if (adv) begin
                addr_d = wrap ? 8'd0 : addr_q + 8'd1;
            end
            if (rd_last && mism) begin
                err_d = err_q + 10'd1;
                if (err_q == 10'd0) begin
                    ffa_d = addr_q;
                    ffp_d = phase;
                end
            end
            if (wrap && (state_q == ST_RD_BIT)) begin
                pass_d = (err_d == 10'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= 8'd0;
            lat_q  <= 2'd0;
            seed_q <= 32'h0;
            err_q  <= 10'd0;
            ffa_q  <= 8'd0;
            ffp_q  <= 2'd0;
            pass_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            lat_q  <= lat_d;
            seed_q <= seed_d;
            err_q  <= err_d;
            ffa_q  <= ffa_d;
            ffp_q  <= ffp_d;
            pass_q <= pass_d;
        end
    end

    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_addr  = ffa_q;
    assign first_fail_phase = ffp_q;

endmodule

// File: tb/tb_memory_bist_ctrl.sv
// Bench for memory_bist_ctrl: RD_LAT=2 and RD_LAT=1 instances, each with
// a latency-honest memory model that can corrupt reads at one address.
module tb_memory_bist_ctrl;
    import memory_bist_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s [2];
    logic        abort_s;
    logic [31:0] seed_s;
    logic [7:0]  fault_addr;
    logic [3:0]  fault_ops;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = 2 - g;
        logic        busy, done, pass, WrEn, RdEn;
        logic [9:0]  err_count;
        logic [7:0]  first_fail_addr, Addr;
        logic [1:0]  first_fail_phase, RdEn_Opcode, ByteAddr;
        logic [4:0]  BitAddr;
        logic [31:0] WrBus, RdBus, word, raw;
        logic [31:0] mem [256];
        logic [17:0] req, prev;
        logic        prev_v = 1'b0;
        int          run = 0;
        int          viol = 0;

        memory_bist_ctrl #(.RD_LAT(LAT), .DEPTH(256)) u_dut (
            .clk(clk), .reset(reset), .start(start_s[g]), .abort(abort_s),
            .seed(seed_s), .busy(busy), .done(done), .pass(pass),
            .err_count(err_count), .first_fail_addr(first_fail_addr),
            .first_fail_phase(first_fail_phase), .WrEn(WrEn), .RdEn(RdEn),
            .RdEn_Opcode(RdEn_Opcode), .Addr(Addr), .BitAddr(BitAddr),
            .ByteAddr(ByteAddr), .WrBus(WrBus), .RdBus(RdBus)
        );

        assign req = {RdEn, Addr, RdEn_Opcode, BitAddr, ByteAddr};

        // run = cycles the current read request has been held, incl. this one
        always @(negedge clk) begin
            if (WrEn) mem[Addr] = WrBus;
            if (RdEn && prev_v && req == prev) begin
                run = run + 1;
            end else begin
                if (prev_v && run != LAT) viol = viol + 1;
                run = RdEn ? 1 : 0;
            end
            prev   = req;
            prev_v = RdEn;
        end

        // data is only valid in the last cycle of the hold window
        always_comb begin
            word = mem[Addr];
            case (RdEn_Opcode)
                OP_BYTE: raw = {24'h0, word[{ByteAddr, 3'b000} +: 8]};
                OP_BIT:  raw = {31'h0, word[BitAddr]};
                default: raw = word;
            endcase
            if (Addr == fault_addr && fault_ops[RdEn_Opcode]) raw = raw ^ 32'h1;
            RdBus = (run >= LAT) ? raw : ~raw;
        end
    end

    typedef struct {
        logic [31:0] seed;
        logic [7:0]  faddr;
        logic [3:0]  fops;
        logic        exp_pass;
        logic [9:0]  exp_err;
        logic [7:0]  exp_ffa;
        logic [1:0]  exp_ffp;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
    } vec_t;

    vec_t vt [7];
    int   n;
    int   vb;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input int g, input logic [31:0] sd);
        @(negedge clk);
        seed_s     = sd;
        start_s[g] = 1'b1;
        @(posedge clk);
        #1 start_s[g] = 1'b0;
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int g, output int cnt);
        cnt = 0;
        while (!(g == 0 ? g_dut[0].done : g_dut[1].done) && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    initial begin
        reset      = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        abort_s    = 1'b0;
        seed_s     = 32'h0;
        fault_addr = 8'h0;
        fault_ops  = 4'h0;

        vt[0] = '{32'h1, 8'h00, 4'b0000, 1'b1, 10'd0, 8'h00, 2'd0,
                  32'h00000001, 32'h80200003, 32'hC0300002};
        vt[1] = '{32'h1, 8'h10, 4'b0111, 1'b0, 10'd3, 8'h10, 2'd0,
                  32'h00000001, 32'h80200003, 32'hC0300002};
        vt[2] = '{32'h0, 8'h00, 4'b0000, 1'b1, 10'd0, 8'h00, 2'd0,
                  32'h00000001, 32'h80200003, 32'hC0300002};
        vt[3] = '{32'h2, 8'h00, 4'b0000, 1'b1, 10'd0, 8'h00, 2'd0,
                  32'h00000002, 32'h00000001, 32'h80200003};
        vt[4] = '{32'h2, 8'h23, 4'b0111, 1'b0, 10'd3, 8'h23, 2'd0,
                  32'h00000002, 32'h00000001, 32'h80200003};
        vt[5] = '{32'h1, 8'h7F, 4'b0010, 1'b0, 10'd1, 8'h7F, 2'd2,
                  32'h00000001, 32'h80200003, 32'hC0300002};
        vt[6] = '{32'h1, 8'h05, 4'b0110, 1'b0, 10'd2, 8'h05, 2'd1,
                  32'h00000001, 32'h80200003, 32'hC0300002};

        tick(3);
        chk("reset_outs", {g_dut[0].busy, g_dut[0].done, g_dut[0].pass,
            g_dut[0].WrEn, g_dut[0].RdEn, g_dut[0].err_count,
            g_dut[0].first_fail_addr, g_dut[0].first_fail_phase,
            g_dut[0].Addr, g_dut[0].RdEn_Opcode, g_dut[0].BitAddr,
            g_dut[0].ByteAddr}, 64'h0);
        chk("reset_wrbus", g_dut[0].WrBus, 64'h0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            fault_addr = vt[i].faddr;
            fault_ops  = vt[i].fops;
            vb         = g_dut[0].viol;
            pulse_start(0, vt[i].seed);
            chk($sformatf("v%0d busy_done", i),
                {g_dut[0].busy, g_dut[0].done}, 64'b10);
            chk($sformatf("v%0d first_wr", i), {g_dut[0].WrEn, g_dut[0].RdEn,
                g_dut[0].Addr, g_dut[0].WrBus}, {1'b1, 1'b0, 8'h00, 32'h0});
            wait_done(0, n);
            chk($sformatf("v%0d cycles", i), n, 2048);
            chk($sformatf("v%0d busy", i), g_dut[0].busy, 0);
            chk($sformatf("v%0d pass", i), g_dut[0].pass, vt[i].exp_pass);
            chk($sformatf("v%0d err", i), g_dut[0].err_count, vt[i].exp_err);
            chk($sformatf("v%0d ffa", i), g_dut[0].first_fail_addr,
                vt[i].exp_ffa);
            chk($sformatf("v%0d ffp", i), g_dut[0].first_fail_phase,
                vt[i].exp_ffp);
            chk($sformatf("v%0d mem0", i), g_dut[0].mem[0], vt[i].w0);
            chk($sformatf("v%0d mem1", i), g_dut[0].mem[1], vt[i].w1);
            chk($sformatf("v%0d mem2", i), g_dut[0].mem[2], vt[i].w2);
            tick(1);
            chk($sformatf("v%0d hold", i), g_dut[0].viol - vb, 0);
        end
        fault_ops = 4'h0;

        // synchronous reset in the middle of FILL, then a clean rerun
        pulse_start(0, 32'h1);
        tick(320);
        chk("fill_at_40", {g_dut[0].WrEn, g_dut[0].RdEn, g_dut[0].Addr},
            {1'b1, 1'b0, 8'h40});
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_outs", {g_dut[0].busy, g_dut[0].done, g_dut[0].pass,
            g_dut[0].WrEn, g_dut[0].RdEn, g_dut[0].err_count,
            g_dut[0].Addr, g_dut[0].WrBus}, 64'h0);
        @(negedge clk) reset = 1'b1;
        pulse_start(0, 32'h1);
        wait_done(0, n);
        chk("post_reset_cycles", n, 2048);
        chk("post_reset_pass", g_dut[0].pass, 1);

        // start while busy is ignored, seed included
        pulse_start(0, 32'h1);
        tick(1100);
        chk("in_rd_byte", {g_dut[0].busy, g_dut[0].RdEn,
            g_dut[0].RdEn_Opcode}, {1'b1, 1'b1, OP_BYTE});
        pulse_start(0, 32'h55);
        wait_done(0, n);
        chk("busy_start_cycles", 1101 + n, 2048);
        chk("busy_start_pass", {g_dut[0].pass, g_dut[0].err_count},
            {1'b1, 10'd0});

        // abort during RD_WORD
        pulse_start(0, 32'h1);
        tick(600);
        chk("in_rd_word", {g_dut[0].busy, g_dut[0].RdEn,
            g_dut[0].RdEn_Opcode}, {1'b1, 1'b1, OP_WORD});
        @(negedge clk) abort_s = 1'b1;
        @(posedge clk);
        #1 abort_s = 1'b0;
        chk("abort_outs", {g_dut[0].busy, g_dut[0].done, g_dut[0].WrEn,
            g_dut[0].RdEn, g_dut[0].Addr}, 64'h0);
        tick(5);
        chk("abort_idle", {g_dut[0].busy, g_dut[0].done}, 64'h0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start_s[0] = 1'b1;
        abort_s    = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        abort_s    = 1'b0;
        chk("start_abort", {g_dut[0].busy, g_dut[0].WrEn}, 64'h0);

        // RD_LAT = 1 instance
        vb = g_dut[1].viol;
        pulse_start(1, 32'h1);
        chk("lat1_busy", g_dut[1].busy, 1);
        wait_done(1, n);
        chk("lat1_cycles", n, 1280);
        chk("lat1_pass", {g_dut[1].pass, g_dut[1].err_count}, {1'b1, 10'd0});
        tick(1);
        chk("lat1_hold", g_dut[1].viol - vb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
